// File: rtl/wptr_full_lvl.sv
// wptr_full_lvl: write-domain pointer and status block of a dual-clock FIFO.
//
// Keeps the binary write address and the Gray write pointer that crosses into
// the read domain. From the read pointer, already synchronised into wclk, it
// derives a registered full flag, a fill level, an almost-full flag and a
// sticky overflow flag.
//
// Ports:
//   wclk          write clock; all state updates on its rising edge
//   wrst          synchronous active-high reset
//   winc          write request from the producer
//   wovf_clr      clears the sticky overflow flag
//   wq2_rptr      read Gray pointer, 2-flop synchronised into wclk
//   wen           memory write enable (winc & ~wfull)
//   waddr         memory write address
//   wptr          registered Gray write pointer for the read-domain synchroniser
//   wfull         registered full flag
//   walmost_full  registered flag: fill level >= AFULL_THRESH
//   wlevel        registered fill level, 0..2^ASIZE
//   woverflow     sticky flag: a write was attempted while full
module wptr_full_lvl #(
  parameter int ASIZE        = 4,
  parameter int AFULL_THRESH = 14
) (
  input  logic             wclk,
  input  logic             wrst,
  input  logic             winc,
  input  logic             wovf_clr,
  input  logic [ASIZE:0]   wq2_rptr,
  output logic             wen,
  output logic [ASIZE-1:0] waddr,
  output logic [ASIZE:0]   wptr,
  output logic             wfull,
  output logic             walmost_full,
  output logic [ASIZE:0]   wlevel,
  output logic             woverflow
);

  localparam logic [ASIZE:0] DEPTH = (ASIZE+1)'(1 << ASIZE);

  function automatic logic [ASIZE:0] bin2gray(input logic [ASIZE:0] b);
    return b ^ (b >> 1);
  endfunction

  // Bit i of the binary value is the XOR of all Gray bits from the MSB down to i.
  function automatic logic [ASIZE:0] gray2bin(input logic [ASIZE:0] g);
    logic [ASIZE:0] b;
    for (int i = 0; i <= ASIZE; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  logic [ASIZE:0] wbin_p1;
  logic [ASIZE:0] wgray_p1;
  logic [ASIZE:0] level_p1;
  logic           full_p1;
  logic           afull_p1;
  logic           ovf_p1;

  logic [ASIZE:0] wbin_next;
  logic [ASIZE:0] wgray_next;
  logic [ASIZE:0] rbin_s;
  logic [ASIZE:0] level_next;
  logic [ASIZE:0] full_ptr;
  logic           full_next;
  logic           afull_next;

  // wen depends only on winc and the registered full flag, never on wq2_rptr.
  assign wen        = winc & ~full_p1;
  assign wbin_next  = wbin_p1 + (ASIZE+1)'(wen);
  assign wgray_next = bin2gray(wbin_next);
  assign rbin_s     = gray2bin(wq2_rptr);
  // Accepted write and any read advance land in the same level computation.
  assign level_next = wbin_next - rbin_s;

  // Full when the write pointer is exactly one lap ahead of the read pointer:
  // in Gray code that means the two MSBs are inverted and the rest match.
  assign full_ptr   = {~wq2_rptr[ASIZE:ASIZE-1], wq2_rptr[ASIZE-2:0]};
  assign full_next  = (wgray_next == full_ptr);
  assign afull_next = (level_next >= (ASIZE+1)'(AFULL_THRESH));

  // ---- register stage p1: pointers and status flags ----
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin_p1  <= '0;
      wgray_p1 <= '0;
      level_p1 <= '0;
      full_p1  <= 1'b0;
      afull_p1 <= 1'b0;
      ovf_p1   <= 1'b0;
    end else begin
      wbin_p1  <= wbin_next;
      wgray_p1 <= wgray_next;
      level_p1 <= level_next;
      full_p1  <= full_next;
      afull_p1 <= afull_next;
      // A new overflow takes priority over a clear in the same cycle.
      if (winc && full_p1)
        ovf_p1 <= 1'b1;
      else if (wovf_clr)
        ovf_p1 <= 1'b0;
    end
  end

  assign waddr        = wbin_p1[ASIZE-1:0];
  assign wptr         = wgray_p1;
  assign wfull        = full_p1;
  assign walmost_full = afull_p1;
  assign wlevel       = level_p1;
  assign woverflow    = ovf_p1;

  // A level of exactly one full FIFO and the full flag must always agree.
  a_level_full: assert property (@(posedge wclk) disable iff (wrst)
    ((level_p1 == DEPTH) == full_p1));

endmodule

// File: tb/tb_wptr_full_lvl.sv
// Bench for wptr_full_lvl: directed stimulus, a word-count model checked on
// every falling edge, plus literal expectations at key points.
module tb_wptr_full_lvl;

  localparam int ASIZE = 4;
  localparam int AFULL = 14;
  localparam int DEPTH = 1 << ASIZE;

  logic             wclk = 1'b0;
  logic             wrst = 1'b1;
  logic             winc = 1'b0;
  logic             wovf_clr = 1'b0;
  logic [ASIZE:0]   wq2_rptr = '0;
  logic             wen;
  logic [ASIZE-1:0] waddr;
  logic [ASIZE:0]   wptr;
  logic             wfull;
  logic             walmost_full;
  logic [ASIZE:0]   wlevel;
  logic             woverflow;

  int vectors = 0;
  int miscompares = 0;

  // Model state: plain word counts, no pointer arithmetic.
  int rd_cnt  = 0;   // words the reader has consumed (as seen through wq2_rptr)
  int m_wr    = 0;   // words accepted since reset
  int m_lvl   = 0;
  bit m_full  = 0;
  bit m_afull = 0;
  bit m_ovf   = 0;
  bit checking = 0;

  wptr_full_lvl #(.ASIZE(ASIZE), .AFULL_THRESH(AFULL)) dut (
    .wclk(wclk), .wrst(wrst), .winc(winc), .wovf_clr(wovf_clr),
    .wq2_rptr(wq2_rptr), .wen(wen), .waddr(waddr), .wptr(wptr),
    .wfull(wfull), .walmost_full(walmost_full), .wlevel(wlevel),
    .woverflow(woverflow)
  );

  always #5 wclk = ~wclk;

  function automatic logic [ASIZE:0] gray(input int n);
    logic [ASIZE:0] b;
    b = n[ASIZE:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: count accepted words and derive every flag from the occupancy.
  always @(posedge wclk) begin
    if (wrst) begin
      m_wr = 0; m_lvl = 0; m_full = 0; m_afull = 0; m_ovf = 0;
      checking = 1;
    end else begin
      if (winc && m_full) m_ovf = 1;
      else if (wovf_clr)  m_ovf = 0;
      if (winc && !m_full) m_wr++;
      m_lvl   = m_wr - rd_cnt;
      m_full  = (m_lvl == DEPTH);
      m_afull = (m_lvl >= AFULL);
    end
  end

  // Compare process: every falling edge once reset has been seen.
  always @(negedge wclk) begin
    if (checking) begin
      chk("m_wen",   wen,          winc && !m_full);
      chk("m_waddr", waddr,        m_wr % DEPTH);
      chk("m_wptr",  wptr,         gray(m_wr));
      chk("m_wfull", wfull,        m_full);
      chk("m_afull", walmost_full, m_afull);
      chk("m_level", wlevel,       m_lvl);
      chk("m_ovf",   woverflow,    m_ovf);
    end
  end

  // Apply inputs, wait for one rising edge, return 1 time unit after it.
  task automatic cyc(input logic r, input logic w, input logic c, input int rd);
    wrst = r; winc = w; wovf_clr = c;
    rd_cnt = rd;
    wq2_rptr = gray(rd);
    @(posedge wclk);
    #1;
  endtask

  initial begin
    // 1: reset and idle
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("t1_wptr",  wptr, 0);
    chk("t1_waddr", waddr, 0);
    chk("t1_level", wlevel, 0);
    chk("t1_full",  wfull, 0);
    chk("t1_afull", walmost_full, 0);
    chk("t1_ovf",   woverflow, 0);
    winc = 1; #1;
    chk("t1_wen_hi", wen, 1);
    winc = 0; #1;
    chk("t1_wen_lo", wen, 0);

    // 2: fill with the reader parked at 0
    for (int i = 1; i <= 16; i++) begin
      cyc(0, 1, 0, 0);
      if (i == 13) chk("t2_afull13", walmost_full, 0);
      if (i == 14) begin
        chk("t2_level14", wlevel, 14);
        chk("t2_afull14", walmost_full, 1);
      end
      if (i == 15) chk("t2_full15", wfull, 0);
    end
    chk("t2_waddr", waddr, 0);
    chk("t2_wptr",  wptr, 5'b11000);
    chk("t2_level", wlevel, 16);
    chk("t2_full",  wfull, 1);

    // 3: overflow attempts, then clear priority
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0);
      chk("t3_wen",  wen, 0);
      chk("t3_wptr", wptr, 5'b11000);
      chk("t3_ovf",  woverflow, 1);
      chk("t3_level", wlevel, 16);
    end
    cyc(0, 1, 1, 0);
    chk("t3_set_wins", woverflow, 1);
    cyc(0, 0, 1, 0);
    chk("t3_cleared", woverflow, 0);

    // 4: reader frees one word, then one more write refills
    cyc(0, 0, 0, 1);
    chk("t4_full0",  wfull, 0);
    chk("t4_level",  wlevel, 15);
    cyc(0, 1, 0, 1);
    chk("t4_full1",  wfull, 1);
    chk("t4_wptr",   wptr, 5'b11001);
    chk("t4_level16", wlevel, 16);

    // 5: wrap-around with a reader trailing by two words
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 70; i++) begin
      cyc(0, 1, 0, (i >= 2) ? i - 2 : 0);
      chk("t5_waddr", waddr, (i + 1) % 16);
      chk("t5_lap",   wptr[ASIZE], ((i + 1) / 16) % 2);
      chk("t5_range", (wlevel >= 1 && wlevel <= 3), 1);
      chk("t5_full",  wfull, 0);
    end

    // 6: reset mid-fill with winc held high
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 9; i++) cyc(0, 1, 0, 0);
    chk("t6_level9", wlevel, 9);
    cyc(1, 1, 0, 0);
    chk("t6_rst_wptr",  wptr, 0);
    chk("t6_rst_waddr", waddr, 0);
    chk("t6_rst_level", wlevel, 0);
    chk("t6_rst_full",  wfull, 0);
    chk("t6_rst_afull", walmost_full, 0);
    chk("t6_rst_ovf",   woverflow, 0);
    wrst = 0; #1;
    chk("t6_resume_addr", waddr, 0);
    chk("t6_resume_wen",  wen, 1);
    cyc(0, 1, 0, 0);
    chk("t6_after_addr",  waddr, 1);
    chk("t6_after_level", wlevel, 1);
    cyc(0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
